// File: rtl/drum_pkg.sv
// Shared types, defaults and fixed-point helpers for the drum sweep controller.
package drum_pkg;

  typedef logic signed [17:0] fix_t;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_PRIME,
    ST_LOAD,
    ST_WAIT,
    ST_WRITE,
    ST_NEXT,
    ST_DONE
  } state_t;

  localparam int DEFAULT_N_ROWS     = 30;
  localparam int DEFAULT_CENTER_ROW = 15;

  // Signed 1.17 x 1.17 product, rescaled back to 1.17 by dropping 17 fraction bits.
  function automatic fix_t fix_mul(input fix_t a, input fix_t b);
    logic signed [35:0] prod;
    prod = 36'(a) * 36'(b);
    return fix_t'(prod >>> 17);
  endfunction

endpackage

// File: rtl/drum_rho_calc.sv
// Amplitude-dependent tension: rho_0 + (sample/16)^2, clamped to rho_max.
module drum_rho_calc
  import drum_pkg::*;
(
  input  fix_t        sample,
  input  logic [17:0] rho_0,
  input  logic [17:0] rho_max,
  output logic [17:0] rho_next
);

  fix_t        scaled;
  fix_t        g;
  logic [18:0] sum;

  // The square is never negative, so g can be added as an unsigned quantity.
  always_comb begin
    scaled   = sample >>> 4;
    g        = fix_mul(scaled, scaled);
    sum      = {1'b0, rho_0} + {1'b0, g};
    rho_next = (sum > {1'b0, rho_max}) ? rho_max : sum[17:0];
  end

endmodule

// File: rtl/drum_sweep_ctrl.sv
// Row-sweep sequencer for the drum column engines; define DRUM_NONLINEAR_RHO_EN
// to make the broadcast tension follow the centre-sample amplitude.
module drum_sweep_ctrl
  import drum_pkg::*;
#(
  parameter int N_ROWS     = DEFAULT_N_ROWS,
  parameter int CENTER_ROW = DEFAULT_CENTER_ROW,
  parameter int ADDR_W     = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  fix_t              init_data,
  input  logic              audio_req,
  input  fix_t              center_in,
  input  logic [17:0]       rho_0,
  input  logic [17:0]       rho_max,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_en,
  output logic              init_wr,
  output logic              load_curr,
  output logic              shift_en,
  output logic              bottom_zero,
  output logic              top_zero,
  output logic [17:0]       rho_eff,
  output fix_t              sample,
  output logic              sample_valid,
  output logic              init_done,
  output logic              overrun
);

  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(N_ROWS - 1);
  localparam logic [ADDR_W-1:0] CENTER   = ADDR_W'(CENTER_ROW);
  localparam logic [ADDR_W:0]   ROWS_EXT = (ADDR_W+1)'(N_ROWS);

  state_t            state, state_next;
  logic [ADDR_W-1:0] r, r_next, rd_next;
  logic [ADDR_W:0]   r_plus2;
  logic              init_started;
  logic              pending;
  logic              accept;
  logic              init_last;
  logic              req_ok;

  assign r_plus2 = {1'b0, r} + (ADDR_W+1)'(2);
  assign req_ok  = audio_req & init_done;

  // The first INIT cycle after reset is a quiet arming cycle, so reset always
  // leaves every strobe low before row 0 is written.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_INIT;
      r            <= '0;
      rd_addr      <= '0;
      init_started <= 1'b0;
    end else begin
      state        <= state_next;
      r            <= r_next;
      rd_addr      <= rd_next;
      init_started <= 1'b1;
    end
  end

  always_comb begin
    state_next   = state;
    r_next       = r;
    rd_next      = rd_addr;
    wr_addr      = '0;
    wr_en        = 1'b0;
    init_wr      = 1'b0;
    load_curr    = 1'b0;
    shift_en     = 1'b0;
    bottom_zero  = 1'b0;
    top_zero     = 1'b0;
    sample_valid = 1'b0;
    accept       = 1'b0;
    init_last    = 1'b0;
    case (state)
      ST_INIT: begin
        if (init_started) begin
          wr_en   = 1'b1;
          init_wr = 1'b1;
          wr_addr = r;
          if (r == LAST_ROW) begin
            init_last  = 1'b1;
            state_next = ST_IDLE;
            r_next     = '0;
          end else begin
            r_next = r + ADDR_W'(1);
          end
        end
      end
      ST_IDLE: begin
        if (pending) begin
          accept     = 1'b1;
          state_next = ST_PRIME;
          r_next     = '0;
          rd_next    = '0;
        end
      end
      ST_PRIME: begin
        state_next = ST_LOAD;
        rd_next    = ADDR_W'(1);
      end
      ST_LOAD: begin
        load_curr   = 1'b1;
        bottom_zero = 1'b1;
        state_next  = ST_WAIT;
      end
      ST_WAIT: state_next = ST_WRITE;
      ST_WRITE: begin
        wr_en      = 1'b1;
        wr_addr    = r;
        shift_en   = 1'b1;
        top_zero   = (r == LAST_ROW);
        state_next = (r == LAST_ROW) ? ST_DONE : ST_NEXT;
      end
      // Read one row ahead of the row being written; the row past the top wraps to 0.
      ST_NEXT: begin
        r_next     = r + ADDR_W'(1);
        rd_next    = (r_plus2 == ROWS_EXT) ? '0 : r_plus2[ADDR_W-1:0];
        state_next = ST_WAIT;
      end
      ST_DONE: begin
        sample_valid = 1'b1;
        state_next   = ST_IDLE;
      end
      default: state_next = ST_INIT;
    endcase
  end

  // A request landing on the accept cycle becomes the next pending request.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending   <= 1'b0;
      overrun   <= 1'b0;
      init_done <= 1'b0;
      sample    <= '0;
    end else begin
      if (init_last) init_done <= 1'b1;
      if (accept) begin
        pending <= req_ok;
      end else if (req_ok) begin
        pending <= 1'b1;
        if (pending) overrun <= 1'b1;
      end
      if (state == ST_WRITE && r == CENTER) sample <= center_in;
    end
  end

`ifdef DRUM_NONLINEAR_RHO_EN
  logic [17:0] rho_next;
  logic [17:0] rho_q;
  logic        unused_inputs;

  drum_rho_calc u_rho_calc (
    .sample   (sample),
    .rho_0    (rho_0),
    .rho_max  (rho_max),
    .rho_next (rho_next)
  );

  always_ff @(posedge clk) begin
    if (reset) rho_q <= rho_0;
    else if (state == ST_DONE) rho_q <= rho_next;
  end

  assign rho_eff       = rho_q;
  assign unused_inputs = ^init_data;
`else
  logic unused_inputs;

  assign rho_eff       = rho_0;
  assign unused_inputs = ^{init_data, rho_max};
`endif

endmodule

// File: doc/drum_sweep_ctrl.md
DRUM_SWEEP_CTRL -- requirements
Module: drum_sweep_ctrl

Interface
REQ-001 Parameter N_ROWS, default 30; rows per column, legal range 3 to 1023.
REQ-002 Parameter CENTER_ROW, default 15; row whose centre-column value is emitted as the audio sample.
REQ-003 Parameter ADDR_W, default 10; width of the M10K row address.
REQ-004 clk  in  1  clock; reset  in  1  synchronous, active-high reset.
REQ-005 init_data  in  18  signed 1.17 initial displacement for the current init row.
REQ-006 audio_req  in  1  one-cycle pulse requesting one time-step sweep.
REQ-007 center_in  in  18  signed 1.17 u_curr of the centre column engine.
REQ-008 rho_0, rho_max  in  18 each  unsigned 1.17 base and ceiling tension.
REQ-009 rd_addr, wr_addr  out  ADDR_W each  broadcast M10K read and write row addresses.
REQ-010 wr_en  out  1  write strobe for the curr and prev M10Ks of all columns; init_wr  out  1  selects init_data as the write source.
REQ-011 load_curr, shift_en  out  1 each  engine strobes: load u_curr from the M10K q, or shift u_bottom<=u_curr and u_curr<=q.
REQ-012 bottom_zero, top_zero  out  1 each  force the bottom or top neighbour to 0.
REQ-013 rho_eff  out  18  tension broadcast to all engines.
REQ-014 sample  out  18, sample_valid  out  1, init_done  out  1, overrun  out  1 (sticky).

Function
REQ-015 FSM states: INIT, IDLE, PRIME, LOAD, WAIT, WRITE, NEXT, DONE.
REQ-016 INIT: one row per cycle for r=0..N_ROWS-1, with wr_addr=r, wr_en=1 and init_wr=1; then init_done=1 and go to IDLE.
REQ-017 IDLE: when a request is pending, clear pending and go to PRIME; otherwise stay in IDLE.
REQ-018 PRIME: rd_addr=0 for one cycle.
REQ-019 LOAD: load_curr=1, bottom_zero=1, row r=0, rd_addr=1.
REQ-020 WAIT: one-cycle read latency with no strobes asserted.
REQ-021 WRITE: wr_en=1, wr_addr=r, shift_en=1, top_zero=(r==N_ROWS-1).
REQ-022 WRITE: when r==CENTER_ROW, sample<=center_in.
REQ-023 WRITE: go to DONE if r==N_ROWS-1, otherwise go to NEXT.
REQ-024 NEXT: r<=r+1 and rd_addr<=r+2, with rd_addr<=0 when r+2 reaches N_ROWS (wrap); go to WAIT.
REQ-025 DONE: sample_valid=1 for exactly one cycle, then go to IDLE.
REQ-026 Sweep latency: sample_valid asserts 2+3*N_ROWS cycles after the IDLE accept cycle (92 cycles for N_ROWS=30).
REQ-027 An audio_req arriving in any state sets the pending flag; several requests before acceptance collapse into one.
REQ-028 A request arriving while pending is already set sets overrun.
REQ-029 An audio_req coincident with the IDLE accept cycle is held as a new pending request.
REQ-030 audio_req is ignored until init_done=1 and does not set overrun.
REQ-031 rho_eff updates only in the DONE cycle; it is held constant during a sweep.
REQ-032 Every strobe not named for a state is 0 in that state.

Reset
REQ-033 Reset takes effect in any state, including mid-INIT and mid-sweep.
REQ-034 After reset: state=INIT and r=0.
REQ-035 After reset: rd_addr=0, wr_addr=0 and all strobes 0.
REQ-036 After reset: sample=0, sample_valid=0, init_done=0, overrun=0, pending=0.
REQ-037 After reset: rho_eff=rho_0.
REQ-038 A mid-sweep reset discards the partial time step and re-runs INIT.

Configuration
REQ-039 With DRUM_NONLINEAR_RHO_EN defined: g=(sample>>>4)*(sample>>>4) in 1.17 and rho_eff=min(rho_0+g, rho_max), with an unsigned compare.
REQ-040 Without DRUM_NONLINEAR_RHO_EN: rho_eff=rho_0 at all times and no multiplier is instantiated.

Structure
REQ-041 Package drum_pkg: the 1.17 type, the FSM state enum, default N_ROWS and CENTER_ROW, and the shared 1.17 signed-multiply function.
REQ-042 Sub-module drum_rho_calc holds the tension computation; it is instantiated only under DRUM_NONLINEAR_RHO_EN.

Verification
REQ-043 Reset, then run 30 cycles with N_ROWS=30 -> wr_en/init_wr high for wr_addr 0..29, and init_done rises in cycle 31.
REQ-044 One audio_req after init_done -> sample_valid one-cycle pulse exactly 92 cycles after accept, with sample equal to center_in at WRITE r=15.
REQ-045 Three audio_req pulses during one sweep -> exactly one follow-on sweep, and overrun=1.
REQ-046 Reset asserted at WRITE r=10 -> next cycle shows all strobes 0, init_done=0, and INIT restarts at wr_addr=0.
REQ-047 With the macro defined, rho_0=0x08000, rho_max=0x0FC00 and sample=0x10000 -> rho_eff=0x08080 after DONE.
REQ-048 With the macro defined and sample=0x1FFFF -> rho_eff equals a value that is not clamped by rho_max.
